// File: rtl/cmp_pkg.sv
// Shared types for the iterative magnitude comparator.
// State encoding and sticky compare-result codes.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    typedef logic [1:0] res_t;

    localparam res_t CMP_EQ = 2'd0;
    localparam res_t CMP_LT = 2'd1;
    localparam res_t CMP_GT = 2'd2;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
// Produces lt/gt; neither set means the chunks are equal.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_lt,
    output logic             o_gt
);

    assign o_lt = (i_a < i_b);
    assign o_gt = (i_a > i_b);

endmodule

// File: rtl/iter_comparator.sv
// Multi-cycle signed/unsigned comparator, CHUNK bits per cycle, MSB first.
// Define ITER_CMP_EARLY_EXIT_EN to stop at the first differing chunk.
module iter_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             lower,
    output logic             greater
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    res_t             r_res;
    res_t             w_res_n;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;
    logic [WIDTH-1:0] w_flip;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_lt;
    logic             w_gt;
    logic             w_diff;
    logic             w_exit;
    logic             w_acc;

    // Flipping the sign bit maps two's complement onto unsigned order.
    always_comb begin
        w_flip = '0;
        w_flip[WIDTH-1] = is_signed;
    end

    always_comb begin
        w_ca = '0;
        w_cb = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) begin
                w_ca = r_a[i*CHUNK +: CHUNK];
                w_cb = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a  (w_ca),
        .i_b  (w_cb),
        .o_lt (w_lt),
        .o_gt (w_gt)
    );

    assign w_diff  = (r_res == CMP_EQ) && (w_lt || w_gt);
    assign w_res_n = w_diff ? (w_lt ? CMP_LT : CMP_GT) : r_res;
    assign w_acc   = (r_state == IDLE) && in_valid;

`ifdef ITER_CMP_EARLY_EXIT_EN
    assign w_exit = (r_idx == '0) || w_diff;
`else
    assign w_exit = (r_idx == '0);
`endif

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_n = RUN;
            RUN:  if (w_exit) w_state_n = HOLD;
            HOLD: if (out_ready) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_res <= CMP_EQ;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
        end else if (w_acc) begin
            r_a   <= a ^ w_flip;
            r_b   <= b ^ w_flip;
            r_idx <= IW'(N - 1);
            r_res <= CMP_EQ;
        end else if (r_state == RUN) begin
            r_res <= w_res_n;
            if (w_exit) begin
                r_eq <= (w_res_n == CMP_EQ);
                r_lt <= (w_res_n == CMP_LT);
                r_gt <= (w_res_n == CMP_GT);
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign equal     = r_eq;
    assign lower     = r_lt;
    assign greater   = r_gt;

endmodule

// File: tb/tb_iter_comparator.sv
// Scoreboard bench for iter_comparator (WIDTH=32, CHUNK=8).
// Latency expectations follow ITER_CMP_EARLY_EXIT_EN.
module tb_iter_comparator;

`ifdef ITER_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [2:0] f;
        int         k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        equal;
    logic        lower;
    logic        greater;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   seen = 1'b0;

    iter_comparator #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .equal     (equal),
        .lower     (lower),
        .greater   (greater)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready) acc_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("flags{eq,lt,gt}", {29'd0, equal, lower, greater}, {29'd0, e.f});
                chk("latency", cyc - acc_cyc, e.k);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input logic [2:0] f, input int kee);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        e.f = f;
        e.k = EE ? kee : 4;
        q.push_back(e);
        a = ta;
        b = tb_;
        is_signed = ts;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {29'd0, equal, lower, greater}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd5, 32'd5, 1'b0, 3'b100, 4); wait_out();
        issue(32'h8000_0000, 32'h1, 1'b1, 3'b010, 1); wait_out();
        issue(32'h8000_0000, 32'h1, 1'b0, 3'b001, 1); wait_out();
        issue(32'h0000_0100, 32'h0000_0200, 1'b0, 3'b010, 3); wait_out();
        issue(32'hFFFF_FFFF, 32'h0, 1'b1, 3'b010, 1); wait_out();
        issue(32'hFFFF_FFFB, 32'h3, 1'b1, 3'b010, 1); wait_out();
        issue(32'h3, 32'hFFFF_FFFB, 1'b1, 3'b001, 1); wait_out();
        issue(32'h1234_5678, 32'h1234_5679, 1'b0, 3'b010, 4); wait_out();

        // Backpressure: result must hold while new operands are ignored
        out_ready = 1'b0;
        issue(32'd3, 32'd9, 1'b0, 3'b010, 4);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            a = 32'd9 + i;
            b = 32'd3;
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_flags", {29'd0, equal, lower, greater}, 32'b010);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_flags_kept", {29'd0, equal, lower, greater}, 32'b010);

        // Reset in the middle of a 4-chunk compare
        issue(32'h1, 32'h2, 1'b0, 3'b010, 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        q.delete();
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_flags", {29'd0, equal, lower, greater}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd7, 32'd3, 1'b0, 3'b001, 4); wait_out();

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iter_comparator.md
# iter_comparator

Parametrised, multi-cycle magnitude comparator for the MIPS CPU datapath. It is the sequential successor of the single-cycle 32-bit equal/lower/greater comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, from the most significant chunk down, and supports a signed or unsigned mode selected per operation. Operands and results move through valid/ready handshakes, so branch-resolution and SLT logic can share one compact unit.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- N (derived, localparam) = WIDTH/CHUNK: number of chunks.
- clk  in  1: single clock; all state updates on its rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- in_valid  in  1: operands a, b, is_signed are valid.
- in_ready  out  1: unit can accept an operation.
- a  in  WIDTH: left operand.
- b  in  WIDTH: right operand.
- is_signed  in  1: 1 = two's-complement compare; 0 = unsigned compare.
- out_valid  out  1: result flags are valid.
- out_ready  in  1: consumer takes the result.
- equal  out  1: a == b.
- lower  out  1: a < b.
- greater  out  1: a > b.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready, capture a, b and is_signed.
  - When is_signed=1, invert bit WIDTH-1 of both captured operands; the signed compare then reduces to an unsigned compare.
  - Set chunk index idx=N-1, clear the sticky result, go to RUN.
- RUN: in_ready=0. Compare chunk idx of both operands (unsigned).
  - First differing chunk sets the sticky result (lt or gt). Later chunks never overwrite it.
  - Exit to HOLD when idx==0, or on a differing chunk if early exit is compiled in.
  - Otherwise idx decrements.
  - On exit: latch the flags, exactly one of equal/lower/greater set. If no chunk differed, equal=1.
- HOLD: out_valid=1, in_ready=0.
  - Flags stay stable until out_valid && out_ready; then go to IDLE.
  - in_valid is ignored.
- The flags keep their last value in IDLE and RUN. They change only at the latch edge.
- Reset (rst_n low at an edge), from any state including mid-RUN: go to IDLE, in_ready=1, out_valid=0, equal=lower=greater=0. The operation in flight is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, equal=0, lower=0, greater=0.
- Acceptance edge E0 → state RUN. After k further edges out_valid=1, where:
  - k = N when early exit is compiled out;
  - k = (N - index of the most significant differing chunk) when early exit is compiled in, and k = N when the operands are equal.
- Minimum latency is 1 cycle; maximum is N cycles.
- Throughput: at most one operation per k+2 cycles (accept, k RUN cycles, HOLD handoff). There is no back-to-back accept in HOLD.
- A simultaneous in_valid and out_ready in HOLD completes the handoff only. The new operand is accepted in the following IDLE cycle.

## Configuration
- ITER_CMP_EARLY_EXIT_EN defined: RUN exits at the first differing chunk, giving data-dependent latency.
- Undefined: RUN always runs N cycles, giving fixed, data-independent latency. Flag values are identical either way.

## Structure
- Package cmp_pkg: state enum (IDLE, RUN, HOLD) and the result encoding constants (CMP_EQ, CMP_LT, CMP_GT).
- Sub-module cmp_chunk: combinational CHUNK-bit unsigned compare producing lt and gt.
- The top holds the FSM, index counter, operand registers and the sticky result.

## Test plan
Configuration WIDTH=32, CHUNK=8 (N=4), early exit on unless stated.
- a=5, b=5, unsigned → equal=1, lower=0, greater=0, out_valid 4 cycles after accept.
- a=0x8000_0000, b=0x0000_0001, is_signed=1 → lower=1, latency 1; same operands with is_signed=0 → greater=1, latency 1.
- a=0x0000_0100, b=0x0000_0200, unsigned → lower=1, latency 3. Then a=0xFFFF_FFFF, b=0x0000_0000, is_signed=1 → lower=1 (-1 < 0), latency 1.
- Hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid with new operands → flags and out_valid stable, in_ready=0, new operands not captured; release out_ready → IDLE, in_ready=1.
- Drive rst_n=0 for one edge during RUN → all outputs 0, in_ready=1. A following compare of a=7, b=3 gives greater=1.
- ITER_CMP_EARLY_EXIT_EN undefined: rerun the second and third cases → identical flags, latency 4 in every case.
